// File: rtl/spi_pkg.sv
// Shared SPI definitions: command-queue FSM states, length codes and the
// length-to-mask helper used by the queue, master and slave.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    STORE
  } spi_state_t;

  localparam logic [1:0] LEN_8  = 2'd0;
  localparam logic [1:0] LEN_16 = 2'd1;
  localparam logic [1:0] LEN_24 = 2'd2;
  localparam logic [1:0] LEN_32 = 2'd3;

  localparam int unsigned CMD_W = 37;

  typedef struct packed {
    logic [2:0]  chip;
    logic [1:0]  len;
    logic [31:0] data;
  } spi_cmd_t;

  // WAIT_BUSY cycle count at which a missing m_busy is declared a timeout
  localparam logic [3:0] START_TIMEOUT = 4'd8;

  function automatic logic [31:0] len_mask(input logic [1:0] len);
    logic [31:0] m;
    case (len)
      LEN_8:   m = 32'h0000_00FF;
      LEN_16:  m = 32'h0000_FFFF;
      LEN_24:  m = 32'h00FF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with combinational head read; DEPTH must be a power of two.
// A push while full is dropped even if a pop happens in the same cycle.
module spi_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_cmd_queue.sv
// Command/response queue in front of an spi_master: issues one transaction at a
// time and stores the masked receive word. Define SPI_CMDQ_TIMEOUT_EN for the start-timeout err flag.
module spi_cmd_queue
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_chip,
  input  logic [1:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        m_start,
  input  logic        m_busy,
  output logic [2:0]  m_chip,
  output logic [1:0]  m_len,
  output logic [31:0] m_tx_data,
  input  logic [31:0] m_rx_data
`ifdef SPI_CMDQ_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  spi_state_t      state;
  spi_state_t      state_nxt;
  spi_cmd_t        cmd_in;
  spi_cmd_t        cmd_head;
  logic [CW-1:0]   cmd_count;
  logic [CW-1:0]   rsp_count;
  logic            cmd_push;
  logic            cmd_pop;
  logic            rsp_push;
  logic            rsp_pop;
  logic [31:0]     rsp_wdata;
  logic            issue_ok;
  logic            start_ph;
  logic            busy_seen;

  assign cmd_in    = {cmd_chip, cmd_len, cmd_data};
  assign cmd_ready = (cmd_count != FULL_CNT);
  assign cmd_push  = cmd_valid && cmd_ready;
  assign rsp_valid = (rsp_count != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_wdata = m_rx_data & len_mask(m_len);

  // Only one transaction is ever in flight, so a free slot (or one being freed
  // this cycle) at issue time guarantees room at STORE.
  assign issue_ok = (cmd_count != '0) && ((rsp_count != FULL_CNT) || rsp_pop);

  spi_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_push),
    .wr_data (cmd_in),
    .pop     (cmd_pop),
    .rd_data (cmd_head),
    .count   (cmd_count)
  );

  spi_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rsp_push),
    .wr_data (rsp_wdata),
    .pop     (rsp_pop),
    .rd_data (rsp_data),
    .count   (rsp_count)
  );

`ifdef SPI_CMDQ_TIMEOUT_EN
  logic [3:0] to_cnt;
  logic       timeout_fire;

  assign timeout_fire = (state == WAIT_BUSY) && !m_busy && !busy_seen &&
                        (to_cnt == START_TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT_BUSY) ? to_cnt + 4'd1 : '0;
      if (timeout_fire) err <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (issue_ok) state_nxt = START;
      START:     if (start_ph) state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (m_busy || busy_seen) state_nxt = WAIT_DONE;
`ifdef SPI_CMDQ_TIMEOUT_EN
        else if (timeout_fire) state_nxt = IDLE;
`endif
      end
      WAIT_DONE: if (!m_busy) state_nxt = STORE;
      STORE:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_start  = 1'b0;
    cmd_pop  = 1'b0;
    rsp_push = 1'b0;
    case (state)
      IDLE:    cmd_pop  = issue_ok;
      START:   m_start  = 1'b1;
      STORE:   rsp_push = 1'b1;
      default: ;
    endcase
  end

  // start_ph marks the second START cycle; busy_seen catches a master that
  // raises m_busy while m_start is still asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_ph  <= 1'b0;
      busy_seen <= 1'b0;
      m_chip    <= '0;
      m_len     <= '0;
      m_tx_data <= '0;
    end else begin
      start_ph  <= (state == START) && !start_ph;
      busy_seen <= (state == START) && (busy_seen || m_busy);
      if (cmd_pop) begin
        m_chip    <= cmd_head.chip;
        m_len     <= cmd_head.len;
        m_tx_data <= cmd_head.data;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Directed self-checking bench for spi_cmd_queue with a behavioural SPI master.
// Build with SPI_CMDQ_TIMEOUT_EN defined to also exercise the err flag.
module tb_spi_cmd_queue;
  import spi_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_chip;
  logic [1:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        m_start;
  logic        m_busy;
  logic [2:0]  m_chip;
  logic [1:0]  m_len;
  logic [31:0] m_tx_data;
  logic [31:0] m_rx_data;
`ifdef SPI_CMDQ_TIMEOUT_EN
  logic        err;
`endif

  logic        master_en;
  logic        a_busy;
  logic        man_busy;
  logic [31:0] a_rx;
  logic [31:0] man_rx;

  assign m_busy    = master_en ? a_busy : man_busy;
  assign m_rx_data = master_en ? a_rx   : man_rx;

  int unsigned n_vec    = 0;
  int unsigned n_bad    = 0;
  int unsigned n_starts = 0;
  int unsigned start_hi = 0;
  int unsigned n_done   = 0;
  logic        start_prev = 1'b0;
  logic [31:0] slave_q[$];
  logic [31:0] tx_log[$];

  spi_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_chip  (cmd_chip),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .m_start   (m_start),
    .m_busy    (m_busy),
    .m_chip    (m_chip),
    .m_len     (m_len),
    .m_tx_data (m_tx_data),
    .m_rx_data (m_rx_data)
`ifdef SPI_CMDQ_TIMEOUT_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [2:0] chip, input logic [1:0] len, input logic [31:0] data);
    int unsigned k = 0;
    cmd_chip  = chip;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("push_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int unsigned k = 0;
    while (!m_start && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(m_start), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int unsigned target);
    int unsigned k = 0;
    while (n_done < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(tag, n_done, target);
  endtask

  task automatic pop_rsp(input string tag, input logic [31:0] exp);
    int unsigned k = 0;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check(tag, rsp_data, exp);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (m_start && !start_prev) n_starts++;
    if (m_start) start_hi++;
    start_prev = m_start;
  end

  // Behavioural master: busy from the second start cycle for 4 cycles, then
  // returns the next queued slave word.
  initial begin : auto_master
    logic [31:0] cap;
    a_busy = 1'b0;
    a_rx   = '0;
    forever begin
      @(negedge clk);
      if (master_en && m_start) begin
        cap = m_tx_data;
        tx_log.push_back(cap);
        @(negedge clk);
        a_busy = 1'b1;
        repeat (4) @(negedge clk);
        check("m_tx_stable", m_tx_data, cap);
        a_rx   = (slave_q.size() != 0) ? slave_q.pop_front() : 32'h0;
        a_busy = 1'b0;
        n_done++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation did not complete");
  end

  initial begin : main
    int unsigned base_s, base_h, base_d;
    rst = 1'b1; cmd_valid = 1'b0; cmd_chip = '0; cmd_len = '0; cmd_data = '0;
    rsp_ready = 1'b0; master_en = 1'b1; man_busy = 1'b0; man_rx = '0;
    tick(3);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_m_start",   32'(m_start),   32'd0);
    check("rst_m_chip",    32'(m_chip),    32'd0);
    check("rst_m_len",     32'(m_len),     32'd0);
    check("rst_m_tx",      m_tx_data,      32'd0);
`ifdef SPI_CMDQ_TIMEOUT_EN
    check("rst_err",       32'(err),       32'd0);
`endif
    rst = 1'b0;
    tick(1);

    // 8-bit transaction, issue latency and start pulse width
    slave_q.push_back(32'h63);
    base_s = n_starts; base_h = start_hi; base_d = n_done;
    push(3'd0, LEN_8, 32'hCA);
    check("lat_idle",  32'(m_start), 32'd0);
    tick(1);
    check("lat_start", 32'(m_start), 32'd1);
    check("m_chip_0",  32'(m_chip),  32'd0);
    check("m_len_0",   32'(m_len),   32'd0);
    check("m_tx_ca",   m_tx_data,    32'hCA);
    wait_done("done_8b", base_d + 1);
    pop_rsp("rsp_8b", 32'h0000_0063);
    check("start_count", n_starts - base_s, 32'd1);
    check("start_width", start_hi - base_h, 32'd2);
    check("rsp_drained", 32'(rsp_valid), 32'd0);
    tx_log.delete();

    // 32-bit transaction
    slave_q.push_back(32'h6324F97D);
    push(3'd5, LEN_32, 32'h9602C5CA);
    wait_start("start_32b");
    check("m_chip_5", 32'(m_chip), 32'd5);
    check("m_len_3",  32'(m_len),  32'd3);
    check("m_tx_32b", m_tx_data,   32'h9602C5CA);
    pop_rsp("rsp_32b", 32'h6324F97D);
    tx_log.delete();

    // 16-bit with garbage upper rx bits; rsp_valid two cycles after busy falls
    master_en = 1'b0;
    push(3'd2, LEN_16, 32'h0000ABCD);
    wait_start("start_16b");
    man_busy = 1'b1;
    tick(3);
    man_rx   = 32'hDEAD65CA;
    man_busy = 1'b0;
    tick(1);
    check("rsp_lat_1", 32'(rsp_valid), 32'd0);
    tick(1);
    check("rsp_lat_2", 32'(rsp_valid), 32'd1);
    check("rsp_16b",   rsp_data,       32'h0000_65CA);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;

    // Back-pressure: 4 responses fill the response FIFO, next 4 commands stall
    master_en = 1'b1;
    base_s = n_starts; base_d = n_done;
    for (int unsigned i = 1; i <= 9; i++) slave_q.push_back(32'(i));
    for (int unsigned i = 1; i <= 4; i++) push(3'd0, LEN_32, 32'h100 + 32'(i));
    wait_done("done_4", base_d + 4);
    tick(5);
    check("txn_4",     n_starts - base_s, 32'd4);
    check("rsp_full_v", 32'(rsp_valid),   32'd1);
    for (int unsigned i = 5; i <= 8; i++) push(3'd0, LEN_32, 32'h100 + 32'(i));
    check("cmd_full", 32'(cmd_ready), 32'd0);
    tick(10);
    check("no_5th", n_starts - base_s, 32'd4);
    cmd_chip = 3'd0; cmd_len = LEN_32; cmd_data = 32'h109; cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    check("rsp_first",    rsp_data,          32'h1);
    check("full_no_push", 32'(cmd_ready),    32'd0);
    tick(1);
    rsp_ready = 1'b0;
    check("ready_after_pop", 32'(cmd_ready), 32'd1);
    tick(1);
    cmd_valid = 1'b0;
    check("cmd_refull", 32'(cmd_ready), 32'd0);
    wait_done("done_5", base_d + 5);
    for (int unsigned i = 2; i <= 9; i++) pop_rsp("drain", 32'(i));
    check("tx_count", 32'(tx_log.size()), 32'd9);
    for (int unsigned i = 0; i < 9; i++)
      check("tx_order", (i < tx_log.size()) ? tx_log[i] : 32'hFFFF_FFFF, 32'h101 + 32'(i));
    tx_log.delete();

    // STORE coinciding with a pop while 3 of 4 entries are occupied
    base_d = n_done;
    slave_q.push_back(32'h11); slave_q.push_back(32'h22); slave_q.push_back(32'h33);
    for (int unsigned i = 0; i < 3; i++) push(3'd1, LEN_8, 32'(i));
    wait_done("done_3", base_d + 3);
    tick(4);
    master_en = 1'b0;
    push(3'd1, LEN_32, 32'h44);
    wait_start("start_st");
    man_busy = 1'b1;
    tick(3);
    man_rx   = 32'h44;
    man_busy = 1'b0;
    tick(1);
    rsp_ready = 1'b1;
    check("st_pop_head", rsp_data, 32'h11);
    tick(1);
    rsp_ready = 1'b0;
    pop_rsp("st_order_b", 32'h22);
    pop_rsp("st_order_c", 32'h33);
    pop_rsp("st_order_d", 32'h44);
    tick(2);
    check("st_empty", 32'(rsp_valid), 32'd0);

    // Reset during WAIT_DONE, then a late busy fall
    push(3'd4, LEN_24, 32'h00ABCDEF);
    wait_start("start_rst");
    man_busy = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_m_start",   32'(m_start),   32'd0);
    check("mid_m_chip",    32'(m_chip),    32'd0);
    check("mid_m_len",     32'(m_len),     32'd0);
    check("mid_m_tx",      m_tx_data,      32'd0);
    rst = 1'b0;
    tick(2);
    man_rx   = 32'h00123456;
    man_busy = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      tick(1);
      check("no_late_rsp", 32'(rsp_valid | m_start), 32'd0);
    end

`ifdef SPI_CMDQ_TIMEOUT_EN
    // m_busy never rises: err appears 11 cycles after m_start rises
    check("err_clear", 32'(err), 32'd0);
    push(3'd6, LEN_8, 32'h5A);
    wait_start("start_to");
    tick(10);
    check("err_early", 32'(err), 32'd0);
    tick(1);
    check("err_set",   32'(err),       32'd1);
    check("to_idle",   32'(m_start),   32'd0);
    check("to_ready",  32'(cmd_ready), 32'd1);
    tick(5);
    check("err_sticky", 32'(err),       32'd1);
    check("to_no_rsp",  32'(rsp_valid), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
